// File: rtl/ptp_gearbox.sv
// ptp_gearbox: two independent valid/ready channels between a narrow pin bus
// and a wide datapath. Pack gathers R narrow beats into one wide word; unpack
// slices a wide word (from one of two sources) back into R narrow beats.
module ptp_gearbox #(
    parameter int NARROW_W  = 8,
    parameter int WIDE_W    = 32,
    parameter int LSB_FIRST = 1
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic                                   abort_i,
    // pack channel
    input  logic                                   pk_valid_i,
    output logic                                   pk_ready_o,
    input  logic [NARROW_W-1:0]                    pk_data_i,
    output logic [$clog2(WIDE_W/NARROW_W)-1:0]     pk_count_o,
    output logic                                   wd_valid_o,
    input  logic                                   wd_ready_i,
    output logic [WIDE_W-1:0]                      wd_data_o,
    // unpack channel
    input  logic                                   up_valid_i,
    output logic                                   up_ready_o,
    input  logic                                   up_sel_i,
    input  logic [WIDE_W-1:0]                      up_a_i,
    input  logic [WIDE_W-1:0]                      up_b_i,
    output logic                                   nb_valid_o,
    input  logic                                   nb_ready_i,
    output logic [NARROW_W-1:0]                    nb_data_o
);

    localparam int R  = WIDE_W / NARROW_W;
    localparam int CW = $clog2(R);
    localparam int RW = $clog2(R + 1);

    // ------------------------------------------------------------------
    // Pack channel
    // ------------------------------------------------------------------
    logic [WIDE_W-1:0] asm_q;
    logic [WIDE_W-1:0] asm_next;
    logic [CW-1:0]     slot;
    logic              pk_last;
    logic              pk_take;

    assign pk_last    = (pk_count_o == CW'(R - 1));
    // Only the completing beat has to wait for the output register to drain.
    assign pk_ready_o = !abort_i && (!pk_last || !wd_valid_o || wd_ready_i);
    assign pk_take    = pk_valid_i && pk_ready_o;
    assign slot       = (LSB_FIRST != 0) ? pk_count_o : (CW'(R - 1) - pk_count_o);

    // Assembly word with the incoming beat dropped into its slot; also feeds
    // the output register directly so the last beat needs no extra cycle.
    always_comb begin
        asm_next = asm_q;
        for (int s = 0; s < R; s++) begin
            if (slot == CW'(s)) asm_next[s*NARROW_W +: NARROW_W] = pk_data_i;
        end
    end

    // Partial-word assembly register and beat counter.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            asm_q      <= '0;
            pk_count_o <= '0;
        end else if (abort_i) begin
            asm_q      <= '0;
            pk_count_o <= '0;
        end else if (pk_take) begin
            asm_q      <= asm_next;
            pk_count_o <= pk_last ? '0 : pk_count_o + 1'b1;
        end
    end

    // Output word register; a completing word wins over a drain in the same cycle.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wd_valid_o <= 1'b0;
            wd_data_o  <= '0;
        end else if (abort_i) begin
            wd_valid_o <= 1'b0;
            wd_data_o  <= '0;
        end else if (pk_take && pk_last) begin
            wd_valid_o <= 1'b1;
            wd_data_o  <= asm_next;
        end else if (wd_ready_i) begin
            wd_valid_o <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Unpack channel
    // ------------------------------------------------------------------
    typedef enum logic {IDLE, SHIFT} ustate_t;

    ustate_t           state_q, state_d;
    logic [RW-1:0]     rem_q, rem_d;
    logic [WIDE_W-1:0] sh_q, sh_d;
    logic              up_take;
    logic              nb_take;

    // A new word may load in the same cycle the last beat leaves.
    assign up_ready_o = !abort_i && ((rem_q == '0) || ((rem_q == RW'(1)) && nb_ready_i));
    assign up_take    = up_valid_i && up_ready_o;
    assign nb_valid_o = (state_q == SHIFT);
    assign nb_take    = nb_valid_o && nb_ready_i;
    assign nb_data_o  = (LSB_FIRST != 0) ? sh_q[NARROW_W-1:0]
                                         : sh_q[WIDE_W-1 -: NARROW_W];

    // Next state: abort, then load, then shift toward the output slice.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        sh_d    = sh_q;
        if (abort_i) begin
            state_d = IDLE;
            rem_d   = '0;
            sh_d    = '0;
        end else if (up_take) begin
            state_d = SHIFT;
            rem_d   = RW'(R);
            sh_d    = up_sel_i ? up_b_i : up_a_i;
        end else if (nb_take) begin
            state_d = (rem_q == RW'(1)) ? IDLE : SHIFT;
            rem_d   = rem_q - 1'b1;
            sh_d    = (LSB_FIRST != 0) ? (sh_q >> NARROW_W) : (sh_q << NARROW_W);
        end
    end

    // Unpack state, remaining-beat counter and shift register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            rem_q   <= '0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            sh_q    <= sh_d;
        end
    end

endmodule
